// File: rtl/alu_exec.sv
// Two-stage ALU execute pipeline with valid/ready flow control on both sides.
// S1 holds the accepted request, S2 holds the computed result and flags.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [15:0]      op_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             illegal;
  } rsp_t;

  req_t             s1;
  rsp_t             s2, nxt;
  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv, accept;
  logic [WIDTH-1:0] sum, diff;
  logic             slt;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !flush && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;

  assign sum  = s1.a + s1.b;
  assign diff = s1.a - s1.b;
  assign slt  = $signed(s1.a) < $signed(s1.b);

  // Overflow: operand signs (B inverted for SUB) agree but the result sign differs.
  always_comb begin
    nxt = '0;
    case (s1.ctrl)
      OP_ADD: begin
        nxt.result = sum;
        nxt.ovf    = (s1.a[WIDTH-1] == s1.b[WIDTH-1]) && (sum[WIDTH-1] != s1.a[WIDTH-1]);
      end
      OP_SUB: begin
        nxt.result = diff;
        nxt.ovf    = (s1.a[WIDTH-1] != s1.b[WIDTH-1]) && (diff[WIDTH-1] != s1.a[WIDTH-1]);
      end
      OP_AND:  nxt.result = s1.a & s1.b;
      OP_OR:   nxt.result = s1.a | s1.b;
      OP_NOR:  nxt.result = ~(s1.a | s1.b);
      OP_SLT:  nxt.result = {{(WIDTH-1){1'b0}}, slt};
      default: nxt.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1       <= '{ctrl: ctrl, a: a, b: b};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 only reloads when S1 actually hands over, so a stalled result stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2 <= nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       op_count <= '0;
    else if (s2_valid && out_ready)  op_count <= op_count + 16'd1;
  end

  assign out_valid = s2_valid;
  assign result    = s2.result;
  assign ovf       = s2.ovf;
  assign illegal   = s2.illegal;
  assign zero      = (s2.result == '0);

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request carries a valid operation.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port ctrl  input  4  ALU control code (0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT, 1100 NOR).
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-010 SHALL have port out_valid  output  1  result registers hold a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-012 SHALL have port result  output  WIDTH  ALU result.
REQ-013 SHALL have port zero  output  1  result == 0.
REQ-014 SHALL have port ovf  output  1  signed overflow (ADD/SUB only, else 0).
REQ-015 SHALL have port illegal  output  1  ctrl was not a listed code.
REQ-016 SHALL have port op_count  output  16  number of results consumed.

Function
REQ-017 SHALL be a two-stage pipeline: S1 registers {ctrl, a, b}; S2 registers {result, zero, ovf, illegal}, each stage with its own valid bit.
REQ-018 SHALL accept a request when in_valid && in_ready; accepted operands are held in S1 unchanged until advanced.
REQ-019 SHALL advance S2 when !s2_valid || out_ready, and S1 into S2 when s1_valid && S2 advances.
REQ-020 SHALL drive in_ready = !flush && (!s1_valid || S1 advances this cycle); in_ready is combinational from out_ready.
REQ-021 SHALL produce out_valid exactly 2 cycles after acceptance with out_ready held high; full throughput of 1 op/cycle.
REQ-022 SHALL hold result, zero, ovf, illegal stable while out_valid && !out_ready.
REQ-023 SHALL compute ADD/SUB modulo 2^WIDTH; ovf = operands' sign (B inverted for SUB) equal and result sign differs.
REQ-024 SHALL compute SLT as signed compare: result = 1 if $signed(a) < $signed(b), else 0, zero-extended.
REQ-025 SHALL compute AND, OR, NOR bitwise over WIDTH.
REQ-026 SHALL, for unlisted ctrl, produce result 0, zero 1, ovf 0, illegal 1, and still complete the handshake.
REQ-027 SHALL compute zero from the final registered result value.
REQ-028 SHALL, on flush, clear s1_valid and s2_valid at the next edge; a request presented during flush is not accepted; op_count unaffected unless the same-cycle out_valid && out_ready handshake completes (it counts).
REQ-029 SHALL increment op_count by 1 on each out_valid && out_ready, wrapping FFFF -> 0000.
REQ-030 SHALL, with both stages full and out_ready low, hold in_ready low; raising out_ready makes in_ready high in that same cycle.

Reset
REQ-031 SHALL, on reset assertion, immediately clear s1_valid, s2_valid, out_valid = 0, result = 0, zero = 1, ovf = 0, illegal = 0, op_count = 0, independent of clk.
REQ-032 SHALL discard any in-flight operation on reset mid-operation; in_ready = 1 while reset is low and flush low after reset.

Verification
REQ-033 ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 -> 2 cycles later result 0x80000000, ovf 1, zero 0, illegal 0, op_count 1.
REQ-034 SUB 5 - 5 then SLT a = 0xFFFFFFFF, b = 1 back-to-back -> consecutive cycles: result 0, zero 1; then result 1, zero 0.
REQ-035 Three requests with out_ready = 0 -> two accepted, in_ready low on third; out_ready high -> results drain in order, none lost or duplicated, op_count 2.
REQ-036 ctrl 1010, a = 3, b = 4 -> result 0, zero 1, illegal 1; NOR a = 0, b = 0 -> result 0xFFFFFFFF.
REQ-037 Flush with both stages full and out_ready = 0 -> out_valid 0 next cycle, op_count unchanged; request during flush not accepted.
REQ-038 Async reset pulse between clock edges with pipeline full -> outputs reach reset values before next edge; op_count wraps 0xFFFF -> 0 after 65536 consumes.
